// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned
// per operation, one Booth step per cycle over an E = WIDTH+1 bit datapath.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   y
);

  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E + 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("booth_mul_seq: WIDTH must be in 2..32");
    end
  endgenerate

  // Handshake: start is accepted on a rising edge only while busy=0; valid is a
  // one-cycle pulse in which y carries the new product, and y holds otherwise.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [E-1:0]    m, acc, q;
  logic            q_m1;
  logic [CW-1:0]   count;

  logic [E-1:0]    a_ext, b_ext;
  logic [E-1:0]    acc_sel;
  logic [E-1:0]    acc_nxt, q_nxt;
  logic            q_m1_nxt;
  logic            accept, last_step;

  // Sign- or zero-extension to E bits lets one datapath serve both modes.
  assign a_ext = {signed_mode & a[WIDTH-1], a};
  assign b_ext = {signed_mode & b[WIDTH-1], b};

  assign accept    = (state == S_IDLE) && start;
  assign last_step = (state == S_RUN) && (count == CW'(E - 1));

  // Booth recode on {q[0], q_m1}, then arithmetic shift of {acc, q, q_m1}.
  always_comb begin
    acc_sel = acc;
    case ({q[0], q_m1})
      2'b10:   acc_sel = acc - m;
      2'b01:   acc_sel = acc + m;
      default: acc_sel = acc;
    endcase
    acc_nxt  = {acc_sel[E-1], acc_sel[E-1:1]};
    q_nxt    = {acc_sel[0], q[E-1:1]};
    q_m1_nxt = q[0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Operand capture and Booth iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (accept) begin
      m     <= a_ext;
      acc   <= '0;
      q     <= b_ext;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (state == S_RUN) begin
      acc   <= acc_nxt;
      q     <= q_nxt;
      q_m1  <= q_m1_nxt;
      count <= count + CW'(1);
    end
  end

  // The low 2*WIDTH bits of the final {acc, q} are the exact product.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      y     <= '0;
    end else begin
      valid <= last_step;
      if (last_step) y <= {acc_nxt[WIDTH-2:0], q_nxt};
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq at WIDTH=8: corner products, busy protection,
// back-to-back starts, mid-operation reset and a short reference-checked sweep.
module tb_booth_mul_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a, b;
  logic           busy, valid;
  logic [2*W-1:0] y;

  int n_vec  = 0;
  int n_miss = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .valid(valid), .y(y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply from idle, check busy during the run, latency and product.
  task automatic do_mul(input string tag, input logic sm, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [2*W-1:0] exp_y);
    int  cyc;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom_range(0, 255); b = $urandom_range(0, 255);
    cyc = 0; busy_ok = 1'b1;
    while (!valid && cyc < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy"}, {31'd0, busy_ok}, 1);
    check({tag, "_y"}, {16'd0, y}, {16'd0, exp_y});
    check({tag, "_busy_at_valid"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int c, n_valid, first_v, second_v;
    logic hold_ok;
    logic [W-1:0] ra, rb;
    logic rs;
    logic [2*W-1:0] ref_y;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_y", {16'd0, y}, 0);
    rst = 1'b0;

    do_mul("s_corner", 1'b1, 8'h80, 8'h80, 16'h4000);
    do_mul("s_mixed",  1'b1, 8'h7F, 8'hFF, 16'hFF81);
    do_mul("s_zero",   1'b1, 8'h00, 8'h80, 16'h0000);
    do_mul("u_max",    1'b0, 8'hFF, 8'hFF, 16'hFE01);
    do_mul("u_shift",  1'b0, 8'h80, 8'h02, 16'h0100);
    do_mul("s_m1sq",   1'b1, 8'hFF, 8'hFF, 16'h0001);
    do_mul("s_negpos", 1'b1, 8'h80, 8'h7F, 16'hC080);
    do_mul("u_bigb",   1'b0, 8'h03, 8'h80, 16'h0180);

    // Busy protection: second start at k+3 and noisy inputs must be ignored.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 8'd3; b = 8'd5;
    n_valid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid) begin
        n_valid++;
        check("busy_prot_y", {16'd0, y}, 32'h000F);
      end
      start = (i == 2);
      a = (i == 2) ? 8'd7 : 8'($urandom_range(0, 255));
      b = (i == 2) ? 8'd7 : 8'($urandom_range(0, 255));
      signed_mode = 1'($urandom_range(0, 1));
    end
    check("busy_prot_count", n_valid, 1);
    check("busy_prot_idle", {31'd0, busy}, 0);

    // Back-to-back: start held high; second operation accepted in the valid cycle.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 8'd2; b = 8'd3;
    @(negedge clk);
    a = 8'd4; b = 8'd5;
    c = 0; first_v = -1; second_v = -1; hold_ok = 1'b1;
    while (c < 30) begin
      @(negedge clk);
      c++;
      if (valid && first_v < 0) begin
        first_v = c;
        check("b2b_y1", {16'd0, y}, 32'h0006);
      end else if (valid && second_v < 0) begin
        second_v = c;
        check("b2b_y2", {16'd0, y}, 32'h0014);
      end else if (first_v >= 0 && second_v < 0 && y !== 16'h0006) begin
        hold_ok = 1'b0;
      end
      if (c == 10) start = 1'b0;
    end
    check("b2b_first", first_v, 9);
    check("b2b_spacing", second_v - first_v, 10);
    check("b2b_hold", {31'd0, hold_ok}, 1);

    // Reset mid-operation: rst sampled at edge k+4.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; a = 8'h7F; b = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_valid", {31'd0, valid}, 0);
    check("rst_mid_y", {16'd0, y}, 0);
    rst = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid) n_valid++;
    end
    check("rst_mid_no_valid", n_valid, 0);
    do_mul("after_rst", 1'b1, 8'h7F, 8'h7F, 16'h3F01);

    // Short random sweep against a behavioural reference product.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs) ref_y = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
      else    ref_y = 16'({8'd0, ra} * {8'd0, rb});
      do_mul("rand", rs, ra, rb, ref_y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
